// File: rtl/block_invaders_pkg.sv
// Shared constants and the scheduler state type for the block_invaders frame logic.
package block_invaders_pkg;

  localparam int VD        = 480;  // first non-visible line
  localparam int VMAX      = 524;  // last line of a frame
  localparam int HMAX      = 799;  // last pixel of a line
  localparam int NUM_UNITS = 4;    // game-logic units sequenced each frame

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_NEXT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/vga_event_decode.sv
// Turns the raw raster position into registered one-cycle blank-start and
// deadline events. Both are qualified by p_tick so that a line position held
// across the four system clocks of one pixel fires only once.
module vga_event_decode #(
  parameter int VD = block_invaders_pkg::VD
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       p_tick_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       blank_ev_o,
  output logic       deadline_ev_o
);

  logic blank_ev_q, blank_ev_d;
  logic deadline_ev_q, deadline_ev_d;

  // Raw event conditions on the current pixel.
  always_comb begin
    blank_ev_d    = p_tick_i && (y_i == 10'(VD)) && (x_i == 10'd0);
    deadline_ev_d = p_tick_i && (y_i == 10'd0)   && (x_i == 10'd0);
  end

  // Register the events so downstream logic sees clean one-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blank_ev_q    <= 1'b0;
      deadline_ev_q <= 1'b0;
    end else begin
      blank_ev_q    <= blank_ev_d;
      deadline_ev_q <= deadline_ev_d;
    end
  end

  assign blank_ev_o    = blank_ev_q;
  assign deadline_ev_o = deadline_ev_q;

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame update sequencer: at the start of vertical blanking it requests an
// update from each game-logic unit in turn (unit 0 first) and flags an overrun
// if the sequence is still running when the next frame begins.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no sequence running; waiting for a blank start event
//   REQ     | first cycle of a request to unit idx
//   WAIT    | request to unit idx held until its upd_done bit is seen
//   NEXT    | one-cycle gap; advance to idx+1 or finish the sequence
module frame_scheduler #(
  parameter int NUM_UNITS = block_invaders_pkg::NUM_UNITS,
  parameter int VD        = block_invaders_pkg::VD,
  parameter int FC_W      = 16
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic                 p_tick,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 pause,
  input  logic [NUM_UNITS-1:0] upd_done,
  input  logic                 clr_overrun,
  output logic [NUM_UNITS-1:0] upd_req,
  output logic                 frame_tick,
  output logic [FC_W-1:0]      frame_count,
  output logic                 busy,
  output logic                 overrun
);

  import block_invaders_pkg::*;

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  sched_state_e           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_UNITS-1:0]   upd_req_q, upd_req_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [FC_W-1:0]        frame_count_q;
  logic                   pause_q;
  logic                   blank_ev;
  logic                   deadline_ev;

  vga_event_decode #(
    .VD(VD)
  ) u_event_decode (
    .clk_i         (clk_100MHz),
    .rst_ni        (reset_n),
    .p_tick_i      (p_tick),
    .x_i           (x),
    .y_i           (y),
    .blank_ev_o    (blank_ev),
    .deadline_ev_o (deadline_ev)
  );

  // pause is delayed alongside the blank event so the gate uses the pause
  // level present on the same pixel that triggered the event.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) pause_q <= 1'b0;
    else          pause_q <= pause;
  end

  // Frame counter runs on every blank start, whether or not updates are paused.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)      frame_count_q <= '0;
    else if (blank_ev) frame_count_q <= frame_count_q + 1'b1;
  end

  // Next-state, unit index, overrun and the registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    upd_req_d = '0;
    busy_d    = 1'b0;

    if (clr_overrun) overrun_d = 1'b0;
    // Set beats clear: a late sequence or a blank start landing mid-sequence.
    if ((state_q != ST_IDLE) && (deadline_ev || blank_ev)) overrun_d = 1'b1;

    if ((state_q != ST_IDLE) && deadline_ev) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (blank_ev && !pause_q) begin
            state_d = ST_REQ;
            idx_d   = '0;
          end
        end
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: if (upd_done[idx_q]) state_d = ST_NEXT;
        ST_NEXT: begin
          if (idx_q != LAST_IDX) begin
            state_d = ST_REQ;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the state being entered so they are registered with it.
    if ((state_d == ST_REQ) || (state_d == ST_WAIT)) upd_req_d[idx_d] = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears upd_req without a clock edge.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      upd_req_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      upd_req_q <= upd_req_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign upd_req     = upd_req_q;
  assign frame_tick  = blank_ev;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: raster positions are driven directly (no full
// 800x525 scan), units answer 5 cycles into their request, and a timestamp
// model predicts every output on every cycle.
module tb_frame_scheduler;

  localparam int N  = 4;
  localparam int VD = 480;

  logic         clk_100MHz = 1'b0;
  logic         reset_n    = 1'b1;
  logic         p_tick     = 1'b0;
  logic [9:0]   x          = 10'd100;
  logic [9:0]   y          = 10'd200;
  logic         pause      = 1'b0;
  logic [N-1:0] upd_done   = '0;
  logic         clr_overrun = 1'b0;
  logic [N-1:0] upd_req;
  logic         frame_tick;
  logic [3:0]   frame_count;
  logic         busy;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;

  frame_scheduler #(
    .NUM_UNITS(N),
    .VD       (VD),
    .FC_W     (4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .pause      (pause),
    .upd_done   (upd_done),
    .clr_overrun(clr_overrun),
    .upd_req    (upd_req),
    .frame_tick (frame_tick),
    .frame_count(frame_count),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is a list of units; each unit's request appears on the edge it
  // is started, done is honoured from the second edge after that, and one
  // empty cycle separates a completion from the next unit.
  logic         m_blank_p = 1'b0, m_dl_p = 1'b0, m_pause_p = 1'b0;
  logic         m_run = 1'b0;
  int           m_unit = 0, m_start_e = 0, m_done_e = -1, m_edge = 0;
  logic [N-1:0] e_req = '0;
  logic         e_busy = 1'b0, e_ftick = 1'b0, e_ovr = 1'b0;
  logic [3:0]   e_fc = 4'd0;

  initial forever begin
    logic blank_now, dl_now, set_ovr;
    @(posedge clk_100MHz or negedge reset_n);
    if (!reset_n) begin
      m_blank_p = 1'b0; m_dl_p = 1'b0; m_pause_p = 1'b0;
      m_run = 1'b0; m_unit = 0; m_done_e = -1;
      e_req = '0; e_busy = 1'b0; e_ftick = 1'b0; e_ovr = 1'b0; e_fc = 4'd0;
    end else begin
      m_edge++;
      blank_now = p_tick && (y == 10'(VD)) && (x == 10'd0);
      dl_now    = p_tick && (y == 10'd0) && (x == 10'd0);
      set_ovr   = m_run && (m_blank_p || m_dl_p);
      if (m_blank_p) e_fc = e_fc + 4'd1;
      if (m_run && m_dl_p) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (m_blank_p && !m_pause_p) begin
          m_run = 1'b1; m_unit = 0; m_done_e = -1; m_start_e = m_edge;
        end
      end else if (m_done_e >= 0) begin
        if (m_unit < N - 1) begin
          m_unit++; m_done_e = -1; m_start_e = m_edge;
        end else begin
          m_run = 1'b0;
        end
      end else if ((m_edge >= m_start_e + 2) && upd_done[m_unit]) begin
        m_done_e = m_edge;
      end
      if (set_ovr)          e_ovr = 1'b1;
      else if (clr_overrun) e_ovr = 1'b0;
      e_busy = m_run;
      e_req  = '0;
      if (m_run && (m_done_e < 0)) e_req[m_unit] = 1'b1;
      e_ftick = blank_now;
      m_blank_p = blank_now; m_dl_p = dl_now; m_pause_p = pause;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(posedge clk_100MHz);
    #1;
    check("upd_req",     32'(upd_req),     32'(e_req));
    check("busy",        32'(busy),        32'(e_busy));
    check("frame_tick",  32'(frame_tick),  32'(e_ftick));
    check("frame_count", 32'(frame_count), 32'(e_fc));
    check("overrun",     32'(overrun),     32'(e_ovr));
  end

  // Record the order in which units are requested.
  int           ord[$];
  logic [N-1:0] prev_req = '0;
  initial forever begin
    @(posedge clk_100MHz);
    #1;
    if ((upd_req != prev_req) && (upd_req != '0)) begin
      for (int i = 0; i < N; i++) if (upd_req[i]) ord.push_back(i);
    end
    prev_req = upd_req;
  end

  // Unit responders: done pulse in the 5th cycle of a request, unless dead.
  logic [N-1:0] dead = '0;
  logic         spur_arm = 1'b0;
  int           age[N];
  initial begin
    for (int i = 0; i < N; i++) age[i] = 0;
    forever begin
      @(negedge clk_100MHz);
      upd_done = '0;
      for (int i = 0; i < N; i++) begin
        if (upd_req[i]) age[i]++; else age[i] = 0;
        if ((age[i] == 5) && !dead[i]) upd_done[i] = 1'b1;
      end
      if (spur_arm && upd_req[1] && (age[1] == 2)) begin
        upd_done[3] = 1'b1;
        spur_arm = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int xx, input int yy, input logic pt);
    x = 10'(xx); y = 10'(yy); p_tick = pt;
    @(negedge clk_100MHz);
  endtask

  task automatic frame(input int mid);
    step(0, VD, 1'b1);
    repeat (mid) step(100, VD + 2, 1'b0);
    step(0, 0, 1'b1);
    repeat (4) step(50, 0, 1'b0);
  endtask

  task automatic check_order(input string name, input int exp_len);
    check({name, "_len"}, 32'(ord.size()), 32'(exp_len));
    for (int i = 0; i < ord.size() && i < exp_len; i++)
      check({name, "_unit"}, 32'(ord[i]), 32'(i));
  endtask

  logic [3:0] fc0;
  logic       found;

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_upd_req",     32'(upd_req),     32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_overrun",     32'(overrun),     32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_frame_tick",  32'(frame_tick),  32'd0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (5) step(100, 200, 1'b0);
    check("idle_no_req", 32'(upd_req), 32'd0);

    // Near misses of the blank/deadline conditions must do nothing.
    step(0, VD, 1'b0);
    step(1, VD, 1'b1);
    step(0, VD - 1, 1'b1);
    step(1, 0, 1'b1);
    repeat (2) step(100, 200, 1'b0);
    check("nearmiss_busy", 32'(busy), 32'd0);
    check("nearmiss_fc",   32'(frame_count), 32'd0);

    // Normal frame with pinned latency and inter-unit gap.
    ord.delete();
    step(0, VD, 1'b1);
    check("lat_ftick", 32'(frame_tick), 32'd1);
    check("lat_req_c1", 32'(upd_req), 32'd0);
    step(100, VD + 2, 1'b0);
    check("lat_req_c2", 32'(upd_req), 32'b0001);
    check("lat_busy", 32'(busy), 32'd1);
    repeat (5) step(100, VD + 2, 1'b0);
    check("gap_req_low", 32'(upd_req), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    step(100, VD + 2, 1'b0);
    check("gap_req_u1", 32'(upd_req), 32'b0010);
    repeat (33) step(100, VD + 2, 1'b0);
    check("norm_busy_pre_dl", 32'(busy), 32'd0);
    step(0, 0, 1'b1);
    repeat (4) step(50, 0, 1'b0);
    check_order("norm_order", 4);
    check("norm_overrun", 32'(overrun), 32'd0);
    check("norm_fc", 32'(frame_count), 32'd1);

    // Spurious done for unit 3 while unit 1 is requested.
    ord.delete();
    spur_arm = 1'b1;
    frame(40);
    check_order("spur_order", 4);
    check("spur_overrun", 32'(overrun), 32'd0);

    // Pause for three frames.
    ord.delete();
    fc0 = frame_count;
    pause = 1'b1;
    repeat (3) frame(5);
    pause = 1'b0;
    check("pause_no_req", 32'(ord.size()), 32'd0);
    check("pause_fc", 32'(frame_count), 32'(fc0 + 4'd3));

    // Unit 2 never finishes: the deadline aborts the sequence.
    ord.delete();
    dead[2] = 1'b1;
    frame(40);
    check_order("ovr_order", 3);
    check("ovr_req", 32'(upd_req), 32'd0);
    check("ovr_busy", 32'(busy), 32'd0);
    check("ovr_flag", 32'(overrun), 32'd1);
    repeat (3) step(50, 0, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    step(50, 0, 1'b0);
    clr_overrun = 1'b0;
    step(50, 0, 1'b0);
    check("ovr_cleared", 32'(overrun), 32'd0);
    dead[2] = 1'b0;
    ord.delete();
    frame(40);
    check_order("ovr_recover", 4);
    check("ovr_recover_flag", 32'(overrun), 32'd0);

    // Second blank start while the sequence is still running.
    ord.delete();
    fc0 = frame_count;
    step(0, VD, 1'b1);
    repeat (8) step(100, VD + 2, 1'b0);
    step(0, VD, 1'b1);
    repeat (40) step(100, VD + 2, 1'b0);
    step(0, 0, 1'b1);
    repeat (4) step(50, 0, 1'b0);
    check_order("dblank_order", 4);
    check("dblank_ovr", 32'(overrun), 32'd1);
    check("dblank_fc", 32'(frame_count), 32'(fc0 + 4'd2));
    clr_overrun = 1'b1;
    step(50, 0, 1'b0);
    clr_overrun = 1'b0;

    // Asynchronous reset while unit 1 is in WAIT.
    step(0, VD, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(100, VD + 2, 1'b0);
      if (upd_req == 4'b0010) found = 1'b1;
    end
    check("rstw_reached_u1", 32'(found), 32'd1);
    repeat (2) step(100, VD + 2, 1'b0);
    check("rstw_pre_req", 32'(upd_req), 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_req",     32'(upd_req),     32'd0);
    check("rstw_busy",    32'(busy),        32'd0);
    check("rstw_fc",      32'(frame_count), 32'd0);
    check("rstw_ovr",     32'(overrun),     32'd0);
    check("rstw_ftick",   32'(frame_tick),  32'd0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (3) step(100, 200, 1'b0);
    check("rstw_idle", 32'(upd_req), 32'd0);
    ord.delete();
    frame(40);
    check_order("rstw_order", 4);
    check("rstw_fc1", 32'(frame_count), 32'd1);

    // 16 more frames after reset: 17 in all, so the 4-bit count reads 1.
    pause = 1'b1;
    repeat (16) frame(3);
    pause = 1'b0;
    check("wrap_fc", 32'(frame_count), 32'd1);

    repeat (3) step(100, 200, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
